uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame sequencer for the UART transmitter. Accepts a parallel byte on a Data_Valid strobe, raises Busy, and serialises start bit, data bits (LSB first), an optional parity bit and stop bit(s) onto TX_OUT, one bit per CLK. CLK is the transmitter bit-rate clock. The block drives Busy to the parity calculator and takes that block's Par_Bit back as an input for the parity slot.

## Interface
- Data_Width, 8, data bits per frame; legal range ≥ 2; bit counter is $clog2(Data_Width) bits wide.
- CLK  input  1  bit-rate clock, all state on posedge.
- RST  input  1  reset RST, asynchronous, active-low.
- P_DATA  input  Data_Width  parallel data; sampled only on accept.
- Data_Valid  input  1  request strobe; accepted only when Busy=0.
- PAR_EN  input  1  1 inserts a parity slot; sampled on accept.
- Par_Bit  input  1  parity value from the parity calculator; sampled at PARITY entry.
- STOP2  input  1  1 requests two stop bits; sampled on accept, active only with UART_TX_STOP2_EN.
- TX_OUT  output  1  serial line, registered, idle high.
- Busy  output  1  frame in progress, registered.

## Operation
- The FSM has the states IDLE, START, DATA, PARITY, STOP and STOP_2 (STOP_2 is present only with UART_TX_STOP2_EN).
- IDLE:
  - TX_OUT=1, Busy=0.
  - Data_Valid=1 accepts the request: latch P_DATA into the shift register, latch PAR_EN and STOP2, and go to START.
  - Data_Valid=0 keeps the FSM in IDLE.
- START: TX_OUT=0, Busy=1. Clear the bit counter and go to DATA.
- DATA:
  - TX_OUT = shift register bit 0. Shift right each cycle and increment the counter.
  - After Data_Width cycles, go to PARITY if latched PAR_EN=1, otherwise go to STOP.
- PARITY: TX_OUT = Par_Bit, sampled at the edge entering this state. Go to STOP.
- STOP:
  - TX_OUT=1, Busy=1.
  - Go to STOP_2 if the latched STOP2=1 and the macro is defined, otherwise go to IDLE.
- STOP_2: TX_OUT=1, Busy=1. Go to IDLE.
- Data_Valid while Busy=1 is ignored. There is no queueing, and P_DATA changes have no effect mid-frame.
- Changes to PAR_EN or STOP2 mid-frame have no effect on the current frame.
- Reset, asynchronous at any point including mid-frame:
  - State goes to IDLE, TX_OUT=1, Busy=0, and the shift register and counter clear.
  - The first accept is possible on the first edge after RST deasserts.
- Encoding of illegal or unreachable states: IDLE on the next edge, TX_OUT=1.

## Timing
- Accept happens at edge E0, with Data_Valid=1 and Busy=0 sampled there.
- After E0: TX_OUT=0 and Busy=1 (start bit).
- Data bit k is driven after edge E0+1+k, for k = 0..Data_Width-1.
- Parity bit, if enabled, is driven after E0+1+Data_Width.
- Stop bit is driven after E0+1+Data_Width+P, where P = PAR_EN.
- Busy is high for 2+Data_Width+P+S cycles, where S = 1 if two stop bits are in use, else 0. It falls together with the return to IDLE.
- Minimum gap between frames:
  - One IDLE cycle, because the next accept is the first edge that sees Busy=0.
  - This guarantees the parity calculator captures P_DATA on the same edge (Data_Valid && ~Busy).
- Par_Bit must be valid by E0+1+Data_Width. The parity calculator provides it from E0+2 onward.
- Latency from Data_Valid to the start bit on the line is 1 cycle.

## Configuration
- UART_TX_STOP2_EN defined: the STOP_2 state exists, and latched STOP2=1 adds a second high stop cycle with Busy held.
- UART_TX_STOP2_EN undefined: the STOP2 port remains but is ignored. Frames always carry exactly one stop bit, and STOP_2 is not synthesised.

## Test plan
- Parity on, even:
  - Stimulus: Data_Width=8, P_DATA=0xA5, PAR_EN=1, calculator PAR_TYP=0, single Data_Valid pulse.
  - Required: TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, then idle 1; Busy high exactly 11 cycles.
- Parity off:
  - Stimulus: P_DATA=0x03, PAR_EN=0.
  - Required: TX_OUT = 0,1,1,0,0,0,0,0,0,1; Busy high 10 cycles.
- Odd parity:
  - Stimulus: P_DATA=0x01, PAR_EN=1, PAR_TYP=1.
  - Required: parity slot = 0.
- Back-to-back:
  - Stimulus: hold Data_Valid=1 with P_DATA=0x55 then 0xAA.
  - Required: second start bit appears exactly one idle cycle after the first stop; mid-frame P_DATA change does not corrupt frame 1.
- Reset mid-frame:
  - Stimulus: assert RST during data bit 4.
  - Required: TX_OUT=1 and Busy=0 immediately; after release, a new Data_Valid sends a full clean frame.
- With UART_TX_STOP2_EN and STOP2=1:
  - Stimulus: P_DATA=0xFF, PAR_EN=0.
  - Required: two stop cycles; Busy high 11 cycles; a Data_Valid during STOP_2 is ignored.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame sequencer for the UART transmitter. A byte offered with Data_Valid
// while the block is idle is latched and sent on TX_OUT as one frame, one bit
// per CLK (CLK is the bit-rate clock):
//   start (0), Data_Width data bits LSB first, optional parity, stop (1),
//   optional second stop (1).
// Busy is high for the whole frame. It is also the handshake the external
// parity calculator uses to capture P_DATA on the accept edge.
//
// Ports
//   CLK         in   bit-rate clock, all state on posedge
//   RST         in   asynchronous reset, active-low
//   P_DATA      in   parallel data, sampled only on accept
//   Data_Valid  in   request strobe, accepted only while Busy=0
//   PAR_EN      in   1 inserts a parity slot, sampled on accept
//   Par_Bit     in   parity value, sampled on the edge entering the parity slot
//   STOP2       in   1 requests two stop bits, sampled on accept
//   TX_OUT      out  serial line, registered, idles high
//   Busy        out  frame in progress, registered
//
// Build option
//   UART_TX_STOP2_EN  when defined, STOP2=1 adds a second stop cycle. When
//                     undefined, the STOP2 port is ignored and every frame has
//                     exactly one stop bit.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int Data_Width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_Width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  Par_Bit,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (Data_Width > 1) ? $clog2(Data_Width) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Data_Width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_STOP2_EN
    STOP   = 3'd4,
    STOP_2 = 3'd5
`else
    STOP   = 3'd4
`endif
  } state_t;

  state_t                state_q;
  logic [Data_Width-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_en_q;
  logic                  tx_q;
  logic                  busy_q;

`ifdef UART_TX_STOP2_EN
  logic                  stop2_q;
`else
  // STOP2 stays on the port list so both builds share one interface.
  logic                  unused_stop2;
  assign unused_stop2 = STOP2;
`endif

  // The outputs are registered. Each transition therefore loads the line
  // value of the state being entered, so TX_OUT shows that state's bit for
  // the whole following cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (Data_Valid) begin
            state_q  <= START;
            shift_q  <= P_DATA;
            par_en_q <= PAR_EN;
`ifdef UART_TX_STOP2_EN
            stop2_q  <= STOP2;
`endif
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        START: begin
          // Leaving the start bit: put data bit 0 on the line.
          state_q <= DATA;
          cnt_q   <= '0;
          tx_q    <= shift_q[0];
          shift_q <= {1'b0, shift_q[Data_Width-1:1]};
          busy_q  <= 1'b1;
        end

        DATA: begin
          busy_q <= 1'b1;
          if (cnt_q == LAST_BIT) begin
            // The last data bit is on the line now. Par_Bit is captured here,
            // on the edge that enters the parity slot.
            if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= Par_Bit;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[Data_Width-1:1]};
          end
        end

        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
          busy_q  <= 1'b1;
        end

        STOP: begin
          tx_q <= 1'b1;
`ifdef UART_TX_STOP2_EN
          if (stop2_q) begin
            state_q <= STOP_2;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end

`ifdef UART_TX_STOP2_EN
        STOP_2: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
`endif

        default: begin
          // Recover from an unreachable encoding by returning to a quiet idle.
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          Par_Bit;
  logic          STOP2 = 1'b0;
  logic          TX_OUT;
  logic          Busy;

  logic          par_typ = 1'b0;

  int checks = 0;
  int passes = 0;

  uart_tx_ctrl #(.Data_Width(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .Par_Bit    (Par_Bit),
    .STOP2      (STOP2),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the parity calculator: captures the byte on the accept edge.
  always @(posedge CLK or negedge RST) begin
    if (!RST) Par_Bit <= 1'b0;
    else if (Data_Valid && !Busy) Par_Bit <= (^P_DATA) ^ par_typ;
  end

  // Frame model: the queue holds the line values still to be shown, the head
  // being the bit currently on the line. An empty queue means idle.
  logic model_q[$];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      model_q.delete();
    end else if (model_q.size() != 0) begin
      void'(model_q.pop_front());
    end else if (Data_Valid) begin
      model_q.push_back(1'b0);
      for (int k = 0; k < DW; k++) model_q.push_back(P_DATA[k]);
      if (PAR_EN) model_q.push_back((^P_DATA) ^ par_typ);
      model_q.push_back(1'b1);
`ifdef UART_TX_STOP2_EN
      if (STOP2) model_q.push_back(1'b1);
`endif
    end
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %s, expected %s", name, got, exp);
  endtask

  // Cycle-by-cycle comparison against the model.
  logic exp_tx, exp_busy;
  always @(negedge CLK) begin
    #2;
    exp_tx   = (model_q.size() != 0) ? model_q[0] : 1'b1;
    exp_busy = (model_q.size() != 0);
    check_bit("model TX_OUT", TX_OUT, exp_tx);
    check_bit("model Busy", Busy, exp_busy);
  end

  // Offers one request and records the line for exp.len() cycles after the
  // accept edge, comparing against a hand-written bit string.
  // dv_release: sample index at which Data_Valid drops.
  // dv_pulse:   sample index at which Data_Valid is pulsed again (-1: none).
  // P_DATA becomes d_mid after the first data bit; PAR_EN/STOP2/par_typ are
  // inverted for two cycles mid-frame.
  task automatic frame_check(input string name, input logic [DW-1:0] d,
                             input logic pe, input logic typ, input logic s2,
                             input logic [DW-1:0] d_mid, input int dv_release,
                             input int dv_pulse, input string exp,
                             input int exp_busy);
    string got;
    int    nb;
    got = "";
    nb  = 0;
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; par_typ = typ; STOP2 = s2; Data_Valid = 1'b1;
    for (int i = 0; i < exp.len(); i++) begin
      @(negedge CLK);
      if (i == dv_release || (dv_pulse >= 0 && i == dv_pulse + 1)) Data_Valid = 1'b0;
      if (i == dv_pulse) Data_Valid = 1'b1;
      if (i == 1) P_DATA = d_mid;
      if (i == 2) begin PAR_EN = ~pe; STOP2 = ~s2; par_typ = ~typ; end
      if (i == 4) begin PAR_EN = pe; STOP2 = s2; par_typ = typ; end
      #2;
      got = {got, (TX_OUT ? "1" : "0")};
      if (Busy) nb++;
    end
    Data_Valid = 1'b0;
    check_str({name, " line"}, got, exp);
    check_int({name, " busy cycles"}, nb, exp_busy);
  endtask

  initial begin
    #7;
    check_bit("reset TX_OUT", TX_OUT, 1'b1);
    check_bit("reset Busy", Busy, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;

    frame_check("even parity A5", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h5A, 0, -1,
                "010100101011", 11);
    frame_check("no parity 03", 8'h03, 1'b0, 1'b0, 1'b0, 8'hFC, 0, -1,
                "01100000011", 10);
    frame_check("odd parity 01", 8'h01, 1'b1, 1'b1, 1'b0, 8'hFE, 0, -1,
                "010000000011", 11);
    frame_check("back-to-back 55/AA", 8'h55, 1'b0, 1'b0, 1'b0, 8'hAA, 11, -1,
                "0101010101100101010111", 20);

    // Reset during data bit 4 of an A5 frame (bit 4 of A5 is 0).
    @(negedge CLK);
    P_DATA = 8'hA5; PAR_EN = 1'b1; par_typ = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
    end
    #2;
    check_bit("data bit 4 before reset", TX_OUT, 1'b0);
    #1 RST = 1'b0;
    #1;
    check_bit("mid-frame reset TX_OUT", TX_OUT, 1'b1);
    check_bit("mid-frame reset Busy", Busy, 1'b0);
    @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    frame_check("post-reset 3C odd", 8'h3C, 1'b1, 1'b1, 1'b0, 8'hC3, 0, -1,
                "000111100111", 11);

`ifdef UART_TX_STOP2_EN
    frame_check("two stop FF", 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 0, 10,
                "01111111111111", 11);
`else
    frame_check("stop2 ignored FF", 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 0, 9,
                "0111111111111", 10);
`endif

    repeat (2) @(negedge CLK);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             passes, checks);
    $fatal(1);
  end

endmodule
